apb_mux_n: RTL and testbench

Parametrised APB decoder/multiplexer connecting the single CPU-side APB master port to `NUM_SLV` peripheral slaves on the 1C102 peripheral bus. It is the successor to the fixed nine-slave mux. The slave count and the address map come from parameters. The slave index is latched at the setup phase, so routing is stable for the whole transfer. The block adds three behaviours: an error response for unmapped addresses and protocol violations, an optional access timeout, and a saturating error counter.

---
 rtl/apb_mux_n.sv | 184 ++++++++++++++++++
 tb/tb_apb_mux_n.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mux_n.sv
// apb_mux_n: parametrised APB decoder/mux from one CPU master to NUM_SLV peripheral slaves.
// Optional access timeout is compiled in when APB_MUX_TIMEOUT_EN is defined.

module apb_mux_n_port #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE       = '1,
    parameter logic [ADDR_WIDTH-1:0] LEN        = '1
) (
    input  logic [ADDR_WIDTH-1:0] addr_cpu,
    input  logic                  psel_cpu,
    input  logic                  enab_cpu,
    input  logic                  in_access,
    input  logic                  req,
    input  logic                  own,
    output logic                  hit,
    output logic                  psel,
    output logic                  enab,
    output logic [ADDR_WIDTH-1:0] addr
);
    assign hit  = (addr_cpu & ~LEN) == BASE;
    // In ACCESS only the latched slave is routed; in IDLE the live decode drives psel.
    assign psel = psel_cpu & (in_access ? own : req);
    assign enab = enab_cpu & in_access & own;
    assign addr = psel ? addr_cpu : '0;
endmodule

module apb_mux_n #(
    parameter int                            NUM_SLV        = 9,
    parameter int                            ADDR_WIDTH     = 32,
    parameter int                            APB_DATA_WIDTH = 32,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE       = '1,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_LEN        = '1,
    parameter int                            TIMEOUT        = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              apb_psel_cpu,
    input  logic                              apb_enab_cpu,
    input  logic                              apb_rw_cpu,
    input  logic [ADDR_WIDTH-1:0]             apb_addr_cpu,
    input  logic [APB_DATA_WIDTH-1:0]         apb_datai_cpu,
    output logic [APB_DATA_WIDTH-1:0]         apb_datao_cpu,
    output logic                              apb_ack_cpu,
    output logic                              apb_err_cpu,
    output logic [7:0]                        apb_err_cnt,
    output logic [NUM_SLV-1:0]                apb_req,
    output logic [NUM_SLV-1:0]                apb_psel,
    output logic [NUM_SLV-1:0]                apb_enab,
    output logic                              apb_rw,
    output logic [APB_DATA_WIDTH-1:0]         apb_datai,
    output logic [NUM_SLV*ADDR_WIDTH-1:0]     apb_addr,
    input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] apb_datao,
    input  logic [NUM_SLV-1:0]                apb_ack
);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                                 state;
    logic [IDX_W-1:0]                       sel_idx;
    logic                                   unmapped;
    logic [NUM_SLV-1:0]                     hit;
    logic [NUM_SLV-1:0]                     sel_oh;
    logic [IDX_W-1:0]                       hit_idx;
    logic [NUM_SLV-1:0][ADDR_WIDTH-1:0]     slv_addr;
    logic [NUM_SLV-1:0][APB_DATA_WIDTH-1:0] slv_rdata;
    logic [APB_DATA_WIDTH-1:0]              rdata_sel;
    logic                                   in_access;
    logic                                   slv_ack;
    logic                                   to_hit;

    // Reset forces IDLE behaviour on the outputs even before the state register clears.
    assign in_access = (state == ACCESS) && !rst;

    // Lowest set bit wins on overlapping windows.
    assign apb_req   = hit & (~hit + NUM_SLV'(1));
    assign apb_rw    = apb_rw_cpu;
    assign apb_datai = apb_datai_cpu;
    assign apb_addr  = slv_addr;
    assign slv_rdata = apb_datao;
    assign slv_ack   = |(apb_ack & sel_oh);

    for (genvar i = 0; i < NUM_SLV; i++) begin : g_slv
        assign sel_oh[i] = !unmapped && (sel_idx == IDX_W'(i));

        apb_mux_n_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .BASE       (SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .LEN        (SLV_LEN[i*ADDR_WIDTH +: ADDR_WIDTH])
        ) u_port (
            .addr_cpu  (apb_addr_cpu),
            .psel_cpu  (apb_psel_cpu),
            .enab_cpu  (apb_enab_cpu),
            .in_access (in_access),
            .req       (apb_req[i]),
            .own       (sel_oh[i]),
            .hit       (hit[i]),
            .psel      (apb_psel[i]),
            .enab      (apb_enab[i]),
            .addr      (slv_addr[i])
        );
    end

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--)
            if (hit[i]) hit_idx = IDX_W'(i);
    end

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (sel_oh[i]) rdata_sel = slv_rdata[i];
    end

`ifdef APB_MUX_TIMEOUT_EN
    logic [15:0] to_cnt;
    assign to_hit = (to_cnt == 16'(TIMEOUT));
`else
    logic unused_timeout;
    assign to_hit         = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // A slave ack in the timeout cycle takes precedence over the timeout error.
    always_comb begin
        apb_ack_cpu   = 1'b0;
        apb_err_cpu   = 1'b0;
        apb_datao_cpu = '0;
        if (!in_access) begin
            if (apb_enab_cpu) begin
                apb_ack_cpu = 1'b1;
                apb_err_cpu = 1'b1;
            end
        end else if (!apb_psel_cpu) begin
            apb_ack_cpu = 1'b0;
        end else if (unmapped) begin
            apb_ack_cpu = 1'b1;
            apb_err_cpu = 1'b1;
        end else if (slv_ack) begin
            apb_ack_cpu   = 1'b1;
            apb_datao_cpu = rdata_sel;
        end else if (to_hit) begin
            apb_ack_cpu = 1'b1;
            apb_err_cpu = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel_idx     <= '0;
            unmapped    <= 1'b0;
            apb_err_cnt <= 8'd0;
`ifdef APB_MUX_TIMEOUT_EN
            to_cnt      <= 16'd0;
`endif
        end else begin
            if (apb_ack_cpu && apb_err_cpu && apb_err_cnt != 8'hFF)
                apb_err_cnt <= apb_err_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (apb_psel_cpu && !apb_enab_cpu) begin
                        state    <= ACCESS;
                        sel_idx  <= hit_idx;
                        unmapped <= ~|hit;
`ifdef APB_MUX_TIMEOUT_EN
                        to_cnt   <= 16'd0;
`endif
                    end
                end
                ACCESS: begin
                    if (apb_ack_cpu || !apb_psel_cpu)
                        state <= IDLE;
`ifdef APB_MUX_TIMEOUT_EN
                    if (!apb_ack_cpu)
                        to_cnt <= to_cnt + 16'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mux_n.sv
// Scoreboard bench for apb_mux_n with three slaves: directed transfers push expected acks,
// a negedge monitor pops and compares every master ack.
`timescale 1ns/1ps
module tb_apb_mux_n;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [NS*DW-1:0] JUNK = {32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             apb_psel_cpu = 1'b0;
    logic             apb_enab_cpu = 1'b0;
    logic             apb_rw_cpu = 1'b0;
    logic [AW-1:0]    apb_addr_cpu = '0;
    logic [DW-1:0]    apb_datai_cpu = '0;
    logic [DW-1:0]    apb_datao_cpu;
    logic             apb_ack_cpu;
    logic             apb_err_cpu;
    logic [7:0]       apb_err_cnt;
    logic [NS-1:0]    apb_req;
    logic [NS-1:0]    apb_psel;
    logic [NS-1:0]    apb_enab;
    logic             apb_rw;
    logic [DW-1:0]    apb_datai;
    logic [NS*AW-1:0] apb_addr;
    logic [NS*DW-1:0] apb_datao = JUNK;
    logic [NS-1:0]    apb_ack = '0;

    apb_mux_n #(
        .NUM_SLV        (NS),
        .ADDR_WIDTH     (AW),
        .APB_DATA_WIDTH (DW),
        .SLV_BASE       ({32'hBF00_0000, 32'hBF00_0000, 32'hBFE0_0000}),
        .SLV_LEN        ({32'h000F_FFFF, 32'h0000_FFFF, 32'h0000_FFFF}),
        .TIMEOUT        (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .apb_psel_cpu  (apb_psel_cpu),
        .apb_enab_cpu  (apb_enab_cpu),
        .apb_rw_cpu    (apb_rw_cpu),
        .apb_addr_cpu  (apb_addr_cpu),
        .apb_datai_cpu (apb_datai_cpu),
        .apb_datao_cpu (apb_datao_cpu),
        .apb_ack_cpu   (apb_ack_cpu),
        .apb_err_cpu   (apb_err_cpu),
        .apb_err_cnt   (apb_err_cnt),
        .apb_req       (apb_req),
        .apb_psel      (apb_psel),
        .apb_enab      (apb_enab),
        .apb_rw        (apb_rw),
        .apb_datai     (apb_datai),
        .apb_addr      (apb_addr),
        .apb_datao     (apb_datao),
        .apb_ack       (apb_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [2:0]  psel;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input logic [31:0] data, input logic err, input logic [2:0] psel);
        exp_t e;
        e.data = data;
        e.err  = err;
        e.psel = psel;
        e.cnt  = 8'(exp_cnt);
        sb_q.push_back(e);
        if (err && exp_cnt < 255) exp_cnt++;
    endtask

    always @(negedge clk) begin
        if (apb_ack_cpu === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", apb_ack_cpu, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ack_data", apb_datao_cpu, mon_e.data);
                chk("ack_err", apb_err_cpu, mon_e.err);
                chk("ack_psel", apb_psel, mon_e.psel);
                chk("ack_err_cnt", apb_err_cnt, mon_e.cnt);
            end
        end
    end

    // One transfer: setup cycle then up to max_cyc ACCESS cycles; slave slv acks in ack_cyc.
    task automatic xfer(input string name, input logic [31:0] addr, input logic [31:0] addr_acc,
                        input logic rw, input int slv, input int ack_cyc, input logic [31:0] rdata,
                        input int max_cyc, input int exp_cyc, input logic cont, input logic hold);
        int          got = 0;
        logic [2:0]  sel = '0;
        logic [95:0] ea  = '0;
        if (slv >= 0) begin
            sel[slv]                = 1'b1;
            ea[slv*32 +: 32]        = addr_acc;
            apb_datao[slv*32 +: 32] = rdata;
        end
        if (!cont) begin
            @(posedge clk); #1;
        end
        apb_psel_cpu  = 1'b1;
        apb_enab_cpu  = 1'b0;
        apb_rw_cpu    = rw;
        apb_addr_cpu  = addr;
        apb_datai_cpu = ~addr;
        @(negedge clk);
        chk({name, "_setup_sel"}, {apb_req, apb_psel, apb_enab}, {sel, sel, 3'b000});
        chk({name, "_bcast"}, {apb_rw, apb_datai}, {rw, ~addr});
        for (int k = 1; k <= max_cyc && got == 0; k++) begin
            @(posedge clk); #1;
            apb_enab_cpu = 1'b1;
            apb_addr_cpu = addr_acc;
            apb_ack      = (slv >= 0 && k == ack_cyc) ? sel : 3'b000;
            @(negedge clk);
            chk({name, "_acc_sel"}, {apb_psel, apb_enab}, {sel, sel});
            if (k == 1) chk({name, "_acc_addr"}, apb_addr, ea);
            if (apb_ack_cpu === 1'b1) got = k;
        end
        chk({name, "_ack_cycle"}, got, exp_cyc);
        @(posedge clk); #1;
        apb_enab_cpu = 1'b0;
        apb_ack      = '0;
        apb_datao    = JUNK;
        if (!hold) apb_psel_cpu = 1'b0;
    endtask

    // Called just after a rising edge: enab without psel must be an IDLE violation ack.
    task automatic probe_idle(input string name);
        expect_ack(32'h0, 1'b1, 3'b000);
        apb_psel_cpu = 1'b0;
        apb_enab_cpu = 1'b1;
        @(negedge clk);
        chk(name, {apb_ack_cpu, apb_err_cpu}, 2'b11);
        @(posedge clk); #1;
        apb_enab_cpu = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_outputs", {apb_ack_cpu, apb_err_cpu, apb_psel, apb_enab, apb_err_cnt, apb_datao_cpu}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // slave1 read, acked in the 2nd ACCESS cycle; slave2 also hits but loses on priority
        expect_ack(32'h1234_5678, 1'b0, 3'b010);
        xfer("rd_s1", 32'hBF00_0010, 32'hBF00_0010, 1'b0, 1, 2, 32'h1234_5678, 6, 2, 1'b0, 1'b0);

        expect_ack(32'hCAFE_F00D, 1'b0, 3'b100);
        xfer("wr_s2", 32'hBF05_0000, 32'hBF05_0000, 1'b1, 2, 1, 32'hCAFE_F00D, 6, 1, 1'b0, 1'b0);

        // address moves into slave2's window during ACCESS: routing stays on slave1
        expect_ack(32'h0BAD_BEEF, 1'b0, 3'b010);
        xfer("addr_chg", 32'hBF00_0010, 32'hBF05_0000, 1'b0, 1, 3, 32'h0BAD_BEEF, 6, 3, 1'b0, 1'b0);

        expect_ack(32'h0, 1'b1, 3'b000);
        xfer("unmapped", 32'h0000_0004, 32'h0000_0004, 1'b0, -1, 0, 32'h0, 4, 1, 1'b0, 1'b0);
        chk("err_cnt_unmapped", apb_err_cnt, 8'd1);

`ifdef APB_MUX_TIMEOUT_EN
        expect_ack(32'h0, 1'b1, 3'b010);
        xfer("timeout", 32'hBF00_0020, 32'hBF00_0020, 1'b0, 1, 0, 32'h55AA_55AA, 8, 5, 1'b0, 1'b0);
        probe_idle("timeout_idle");
`else
        xfer("no_timeout", 32'hBF00_0020, 32'hBF00_0020, 1'b0, 1, 0, 32'h55AA_55AA, 12, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        probe_idle("no_timeout_idle");
`endif

        // slave ack in the timeout cycle wins
        expect_ack(32'h600D_CAFE, 1'b0, 3'b010);
        xfer("tmo_tie", 32'hBF00_0030, 32'hBF00_0030, 1'b0, 1, 5, 32'h600D_CAFE, 8, 5, 1'b0, 1'b0);

        // abort: psel drops before any ack
        xfer("abort", 32'hBF00_0040, 32'hBF00_0040, 1'b0, 1, 0, 32'h1111_1111, 2, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("abort_err_cnt", apb_err_cnt, 8'(exp_cnt));
        probe_idle("abort_idle");

        // back-to-back: setup follows the ack edge directly
        expect_ack(32'hAAAA_0001, 1'b0, 3'b010);
        xfer("b2b_1", 32'hBF00_0100, 32'hBF00_0100, 1'b0, 1, 1, 32'hAAAA_0001, 4, 1, 1'b0, 1'b1);
        expect_ack(32'hAAAA_0002, 1'b0, 3'b100);
        xfer("b2b_2", 32'hBF06_0000, 32'hBF06_0000, 1'b0, 2, 1, 32'hAAAA_0002, 4, 1, 1'b1, 1'b0);

        for (int n = 0; n < 256; n++) begin
            expect_ack(32'h0, 1'b1, 3'b000);
            xfer("sat", 32'h0000_0008, 32'h0000_0008, 1'b0, -1, 0, 32'h0, 4, 1, 1'b0, 1'b0);
        end
        chk("err_cnt_sat", apb_err_cnt, 8'hFF);

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        chk("err_cnt_rst", apb_err_cnt, 8'd0);

        expect_ack(32'h3C3C_3C3C, 1'b0, 3'b001);
        xfer("rd_s0", 32'hBFE0_0020, 32'hBFE0_0020, 1'b0, 0, 1, 32'h3C3C_3C3C, 4, 1, 1'b0, 1'b0);

        @(posedge clk); #1;
        chk("sb_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
